// File: rtl/cpu_pkg.sv
// Shared pipeline constants and types for the ID-stage hazard logic.
//   PIPE_DEPTH      : number of stages in the core pipeline
//   NUM_REGS_DEF    : default architectural register count
//   REG_ADDR_W_DEF  : default register address width
//   WB_LATENCY_DEF  : issue-to-writeback distance seen from ID
//   pc_state_e      : control-flow FSM states
package cpu_pkg;

  localparam int PIPE_DEPTH     = 5;
  localparam int NUM_REGS_DEF   = 32;
  localparam int REG_ADDR_W_DEF = 5;
  // Producer leaves ID and writes back in WB; the stages between ID and WB
  // (EX, MEM, WB) are the cycles a consumer has to wait.
  localparam int WB_LATENCY_DEF = PIPE_DEPTH - 2;

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_PC = 1'b1
  } pc_state_e;

  // 16-bit saturating increment used for the stall statistics counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pc_hazard_fsm.sv
// Control-flow hazard FSM. After a branch/call/ret is accepted it holds
// pc_hazard until the PC unit reports the resolved target, or until the
// wait has lasted PC_TIMEOUT unfrozen cycles, which raises a one-cycle
// pc_timeout_err and returns to IDLE.
//   clk, rst        : clock, async active-low reset
//   freeze          : pipeline freeze, holds the timer
//   start           : control instruction accepted this cycle
//   pc_update       : target resolved pulse (wins over timeout)
//   pc_hazard       : FSM is in WAIT_PC
//   pc_timeout_err  : one-cycle pulse on the cycle the wait expires
module pc_hazard_fsm
  import cpu_pkg::*;
#(
  parameter int PC_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic freeze,
  input  logic start,
  input  logic pc_update,
  output logic pc_hazard,
  output logic pc_timeout_err
);

  localparam int TW = $clog2(PC_TIMEOUT + 1);

  pc_state_e       state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    pc_timeout_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WAIT_PC;
          timer_d = '0;
        end
      end
      WAIT_PC: begin
        if (pc_update) begin
          state_d = IDLE;
        end else if (!freeze) begin
          // Gated by !freeze so a freeze parked on the last count does not
          // produce more than one pulse.
          if (timer_q == TW'(PC_TIMEOUT - 1)) begin
            pc_timeout_err = 1'b1;
            state_d        = IDLE;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pc_hazard = (state_q == WAIT_PC);

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard. One countdown per architectural register
// marks an in-flight write; any enabled read port that addresses a nonzero
// counter stalls the front end. Control instructions hand off to
// pc_hazard_fsm, which holds PC_hazard until the target resolves.
//   clk, rst        : clock, async active-low reset
//   freeze          : whole-pipeline stall, holds all state
//   issue_*         : instruction currently in ID
//   rd_en, rd_addr  : per-port source reads (port i at [i*REG_ADDR_W +: REG_ADDR_W])
//   pc_update       : PC control target-resolved pulse
//   data_hazard     : stall IF/IFID, bubble IDEX
//   PC_hazard       : control hazard active
//   hazard_port     : per-port hit mask
//   pc_timeout_err  : WAIT_PC expired
//   stall_count     : saturating count of hazard cycles (frozen ones too)
module hazard_scoreboard
  import cpu_pkg::*;
#(
  parameter int NUM_REGS     = NUM_REGS_DEF,
  parameter int REG_ADDR_W   = REG_ADDR_W_DEF,
  parameter int NUM_RD_PORTS = 2,
  parameter int WB_LATENCY   = WB_LATENCY_DEF,
  parameter int PC_TIMEOUT   = 15,
  parameter int ZERO_REG     = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               freeze,
  input  logic                               issue_valid,
  input  logic                               issue_wr_en,
  input  logic [REG_ADDR_W-1:0]              issue_rd,
  input  logic                               issue_ctrl,
  input  logic [NUM_RD_PORTS-1:0]            rd_en,
  input  logic [NUM_RD_PORTS*REG_ADDR_W-1:0] rd_addr,
  input  logic                               pc_update,
  output logic                               data_hazard,
  output logic                               PC_hazard,
  output logic [NUM_RD_PORTS-1:0]            hazard_port,
  output logic                               pc_timeout_err,
  output logic [15:0]                        stall_count
);

  localparam int CW   = $clog2(WB_LATENCY + 1);
  localparam int SPAN = 1 << REG_ADDR_W;

  logic [NUM_REGS-1:0][CW-1:0] cnt;
  logic [SPAN-1:0]             pend;
  logic                        accept, wr_go;

  // Pending bitmap padded out to the full address space so out-of-range
  // addresses read a constant zero instead of needing a bounds compare.
  always_comb begin
    pend = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (!(ZERO_REG != 0 && r == 0)) pend[r] = |cnt[r];
    end
  end

  for (genvar i = 0; i < NUM_RD_PORTS; i++) begin : g_port
    assign hazard_port[i] = rd_en[i] & pend[rd_addr[i*REG_ADDR_W +: REG_ADDR_W]];
  end

  assign data_hazard = |hazard_port;
  assign accept      = issue_valid & ~freeze & ~data_hazard & ~PC_hazard;
  assign wr_go       = accept & issue_wr_en &
                       ~(ZERO_REG != 0 && issue_rd == '0);

  // A reload overrides the decrement: with fixed latency the newest
  // writer of a register is always the last to reach writeback.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!freeze) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (wr_go && issue_rd == REG_ADDR_W'(r))
          cnt[r] <= CW'(WB_LATENCY);
        else if (cnt[r] != '0)
          cnt[r] <= cnt[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          stall_count <= '0;
    else if (data_hazard | PC_hazard)  stall_count <= sat_inc16(stall_count);
  end

  pc_hazard_fsm #(
    .PC_TIMEOUT (PC_TIMEOUT)
  ) u_pc_fsm (
    .clk            (clk),
    .rst            (rst),
    .freeze         (freeze),
    .start          (accept & issue_ctrl),
    .pc_update      (pc_update),
    .pc_hazard      (PC_hazard),
    .pc_timeout_err (pc_timeout_err)
  );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard. The reference tracks time as a count of
// unfrozen cycles: a register is pending while that count is within
// WB_LATENCY of its last accepted write, and a control wait expires when
// PC_TIMEOUT unfrozen cycles have passed since the branch.
module tb_hazard_scoreboard;

  localparam int NR = 32, AW = 5, NP = 2, L = 3, TO = 15;

  logic          clk = 1'b0, rst = 1'b0;
  logic          freeze = 0, issue_valid = 0, issue_wr_en = 0, issue_ctrl = 0, pc_update = 0;
  logic [AW-1:0] issue_rd = '0;
  logic [NP-1:0] rd_en = '0;
  logic [NP*AW-1:0] rd_addr = '0;
  logic          data_hazard, PC_hazard, pc_timeout_err;
  logic [NP-1:0] hazard_port;
  logic [15:0]   stall_count;

  hazard_scoreboard #(
    .NUM_REGS(NR), .REG_ADDR_W(AW), .NUM_RD_PORTS(NP),
    .WB_LATENCY(L), .PC_TIMEOUT(TO), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .issue_valid(issue_valid),
    .issue_wr_en(issue_wr_en), .issue_rd(issue_rd), .issue_ctrl(issue_ctrl),
    .rd_en(rd_en), .rd_addr(rd_addr), .pc_update(pc_update),
    .data_hazard(data_hazard), .PC_hazard(PC_hazard), .hazard_port(hazard_port),
    .pc_timeout_err(pc_timeout_err), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  // reference model state
  int act = 0;          // unfrozen cycles elapsed
  int wr_act[NR];       // act value when the last write to r was accepted
  int br_act = 0;       // act value when the pending branch was accepted
  bit in_wait = 0;
  int hz_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit pending(input int r);
    if (r >= NR || r == 0) return 0;
    return act <= wr_act[r] + L;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NR; r++) wr_act[r] = -1000;
    in_wait = 0;
    hz_cnt  = 0;
  endtask

  // One clock: drive at negedge, check combinational/registered outputs,
  // then advance the model across the posedge.
  task automatic cycle(input logic v, input logic we, input logic [AW-1:0] rd,
                       input logic c, input logic fz, input logic [NP-1:0] en,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic pu);
    logic [NP-1:0] ep;
    logic edh, eph, acc, eerr;
    @(negedge clk);
    issue_valid = v; issue_wr_en = we; issue_rd = rd; issue_ctrl = c;
    freeze = fz; rd_en = en; rd_addr = {a1, a0}; pc_update = pu;
    #1;
    ep[0] = en[0] && pending(int'(a0));
    ep[1] = en[1] && pending(int'(a1));
    edh   = |ep;
    eph   = in_wait;
    acc   = v && !fz && !edh && !eph;
    eerr  = in_wait && !pu && !fz && (act - br_act - 1 == TO - 1);
    chk("hazard_port", 32'(hazard_port), 32'(ep));
    chk("data_hazard", 32'(data_hazard), 32'(edh));
    chk("PC_hazard", 32'(PC_hazard), 32'(eph));
    chk("pc_timeout_err", 32'(pc_timeout_err), 32'(eerr));
    chk("stall_count", 32'(stall_count), 32'(hz_cnt));
    @(posedge clk);
    if ((edh || eph) && hz_cnt < 16'hFFFF) hz_cnt++;
    if (acc && we && rd != 0) wr_act[rd] = act;
    if (in_wait) begin
      if (pu || eerr) in_wait = 0;
    end else if (acc && c) begin
      in_wait = 1;
      br_act  = act;
    end
    if (!fz) act++;
  endtask

  // Mid-cycle async reset with a pending read driven: outputs must drop at once.
  task automatic do_reset();
    @(negedge clk);
    rd_en = '1; rd_addr = {AW'(5), AW'(5)};
    #2 rst = 1'b0;
    #1;
    chk("rst_data_hazard", 32'(data_hazard), 0);
    chk("rst_PC_hazard", 32'(PC_hazard), 0);
    chk("rst_hazard_port", 32'(hazard_port), 0);
    chk("rst_timeout", 32'(pc_timeout_err), 0);
    chk("rst_stall_count", 32'(stall_count), 0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("init_data_hazard", 32'(data_hazard), 0);
    chk("init_PC_hazard", 32'(PC_hazard), 0);
    chk("init_stall_count", 32'(stall_count), 0);
    rst = 1'b1;

    // write r5, dependent read on port 1 until it is accepted
    cycle(1, 1, 5, 0, 0, 2'b00, 0, 0, 0);
    repeat (4) cycle(1, 0, 0, 0, 0, 2'b10, 0, 5, 0);
    // write r7 twice back to back, then read r7
    cycle(1, 1, 7, 0, 0, 2'b00, 0, 0, 0);
    cycle(1, 1, 7, 0, 0, 2'b00, 0, 0, 0);
    repeat (5) cycle(1, 0, 0, 0, 0, 2'b01, 7, 0, 0);
    // r0 never tracked; rd_en=0 on a pending address never hits
    cycle(1, 1, 0, 0, 0, 2'b00, 0, 0, 0);
    repeat (3) cycle(1, 0, 0, 0, 0, 2'b11, 0, 0, 0);
    cycle(1, 1, 9, 0, 0, 2'b00, 0, 0, 0);
    repeat (2) cycle(1, 0, 0, 0, 0, 2'b00, 9, 9, 0);
    // branch resolved after 4 cycles, issue ignored meanwhile
    cycle(1, 0, 0, 1, 0, 2'b00, 0, 0, 0);
    repeat (3) cycle(1, 1, 3, 0, 0, 2'b00, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 2'b00, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 2'b00, 0, 0, 1);   // pc_update while IDLE
    // branch times out, with a 5-cycle freeze in the middle
    cycle(1, 1, 4, 1, 0, 2'b00, 0, 0, 0);
    repeat (6) cycle(0, 0, 0, 0, 0, 2'b01, 4, 0, 0);
    repeat (5) cycle(1, 0, 0, 0, 1, 2'b01, 4, 0, 0);
    repeat (12) cycle(0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    // reset with r5 loaded, then r5 must be clear
    cycle(1, 1, 5, 0, 0, 2'b00, 0, 0, 0);
    do_reset();
    cycle(1, 0, 0, 0, 0, 2'b11, 5, 5, 0);

    // randomized traffic over a small register window to force collisions
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            AW'($urandom_range(0, 7)), $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) == 0, NP'($urandom_range(0, 3)),
            AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
            $urandom_range(0, 19) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
